ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-master, one-slave arbiter that shares a single SRAM-like memory port between the instruction fetch path (IF) and the data access path (MEM) of the RV32 core. It uses the same req/addr_ok/data_ok split-transaction handshake on all sides. An in-order owner FIFO routes each returned data_ok/rdata back to the master whose request was accepted. It sits between the IF/MEM stages and the unified RAM/bus interface.

## Interface
- XLEN, 32, data/address width.
- DEPTH, 4, maximum outstanding accepted requests; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req, if_write  in  1  IF request / write flag.
- if_wstrb  in  XLEN/8  IF byte strobes.
- if_addr, if_wdata  in  XLEN  IF address / write data.
- if_addr_ok, if_data_ok  out  1  IF request accepted / response valid.
- if_rdata  out  XLEN  IF read data.
- mem_req, mem_write, mem_wstrb, mem_addr, mem_wdata  in  as IF  MEM request fields.
- mem_addr_ok, mem_data_ok  out  1  MEM accept / response.
- mem_rdata  out  XLEN  MEM read data.
- ram_req, ram_write, ram_wstrb, ram_addr, ram_wdata  out  as IF  request to the slave.
- ram_addr_ok, ram_data_ok  in  1  slave accept / response.
- ram_rdata  in  XLEN  slave read data.
- err  out  1  sticky protocol error flag.

## Operation
- Handshake: a request is accepted in any cycle where req & addr_ok. A master holds req and its fields stable until accepted. Every accepted request, read or write, gets exactly one data_ok, in acceptance order.
- Grant is combinational, fixed priority: MEM over IF.
  - grant_mem = mem_req & ~full.
  - grant_if = if_req & ~mem_req & ~full.
- The granted master's fields are muxed onto ram_*.
- ram_req = grant_mem | grant_if.
- Fields are don't-care when ram_req=0 and are driven from IF in that case.
- Acceptance outputs:
  - mem_addr_ok = grant_mem & ram_addr_ok.
  - if_addr_ok = grant_if & ram_addr_ok.
  - The non-granted master never sees addr_ok.
- A request that is not accepted may lose the grant in a later cycle to a newly arriving MEM request. This is legal because nothing has been committed.
- Owner FIFO, DEPTH entries of 1 bit (0=IF, 1=MEM):
  - push on ram_req & ram_addr_ok, writing the owner bit;
  - pop on ram_data_ok & ~empty.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave count unchanged.
- full = (count == DEPTH). Grant is blocked while full, even if a pop occurs in the same cycle; no bypass.
- Response routing, combinational from the FIFO head:
  - if_data_ok = ram_data_ok & ~empty & (head==0).
  - mem_data_ok = ram_data_ok & ~empty & (head==1).
  - ram_rdata drives both if_rdata and mem_rdata unconditionally.
- Protocol violation: ram_data_ok while empty sets err. The response is dropped, no data_ok is given to either master, and the FIFO is unchanged. err clears only on rst.
- Flush is not handled here. A master that abandons an accepted request must still consume its data_ok.

## Timing
- Reset (async assert, release synchronous to clk): count=0, pointers=0, err=0.
- While rst=1, ram_req, if_addr_ok, mem_addr_ok, if_data_ok and mem_data_ok are forced to 0.
- Request path is zero-latency combinational: master req → ram_req, and ram_addr_ok → master addr_ok, in the same cycle.
- Response path is zero-latency combinational: ram_data_ok → master data_ok in the same cycle.
- The slave may assert data_ok no earlier than the cycle after acceptance. A data_ok in the acceptance cycle is treated against the pre-push FIFO state.
- Throughput is one acceptance per cycle, up to DEPTH outstanding. Sustained back-to-back operation needs the slave to return one response per cycle.
- Simultaneous if_req and mem_req: MEM is accepted first. IF is accepted in the first cycle in which mem_req=0 and ~full.
- Reset mid-transaction: all outstanding ownership is lost. The slave must also be reset, and later stray ram_data_ok sets err.

## Test plan
- Single IF read to 0x100, slave accepts immediately and returns 0xDEADBEEF 2 cycles later. Expect if_addr_ok=1 in cycle 0, if_data_ok=1 with if_rdata=0xDEADBEEF in cycle 2, mem_data_ok=0 throughout, count back to 0.
- if_req and mem_req both asserted in cycle 0. Expect mem accepted in cycle 0 and IF accepted in cycle 1 with mem_req dropped. Responses return in order: MEM data_ok first, then IF.
- Slave stalls returns; IF issues 5 back-to-back reads with DEPTH=4. Expect 4 accepts, then ram_req=0 with if_addr_ok=0 while full. Expect the 5th accept one cycle after the first data_ok pops, and no accept in the pop cycle itself.
- Interleave accepts as IF, MEM, IF, MEM with pointer wrap (10+ transactions). Each data_ok is routed to the correct master per acceptance order.
- Stray ram_data_ok with the FIFO empty. Expect err=1 sticky, no master data_ok, count stays 0. Assert rst → err=0.
- Assert rst with 3 requests outstanding. Expect ram_req and all addr_ok/data_ok at 0 immediately (asynchronously), and count=0 after release.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - fixed-priority two-master arbiter for a split-transaction memory port
// MEM wins over IF; a 1-bit owner FIFO routes responses back in acceptance order.
module ram_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic              if_write,
  input  logic [XLEN/8-1:0] if_wstrb,
  input  logic [XLEN-1:0]   if_addr,
  input  logic [XLEN-1:0]   if_wdata,
  output logic              if_addr_ok,
  output logic              if_data_ok,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic              mem_addr_ok,
  output logic              mem_data_ok,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              ram_req,
  output logic              ram_write,
  output logic [XLEN/8-1:0] ram_wstrb,
  output logic [XLEN-1:0]   ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  input  logic              ram_addr_ok,
  input  logic              ram_data_ok,
  input  logic [XLEN-1:0]   ram_rdata,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] owner_q, owner_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             err_q, err_d;

  logic full, empty, grant_mem, grant_if, push, pop, head;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = owner_q[rptr_q];

  // Full blocks grant even when a pop lands in the same cycle: no bypass path.
  assign grant_mem = ~rst & mem_req & ~full;
  assign grant_if  = ~rst & if_req & ~mem_req & ~full;

  assign ram_req   = grant_mem | grant_if;
  assign ram_write = grant_mem ? mem_write : if_write;
  assign ram_wstrb = grant_mem ? mem_wstrb : if_wstrb;
  assign ram_addr  = grant_mem ? mem_addr  : if_addr;
  assign ram_wdata = grant_mem ? mem_wdata : if_wdata;

  assign mem_addr_ok = grant_mem & ram_addr_ok;
  assign if_addr_ok  = grant_if  & ram_addr_ok;

  assign push = ram_req & ram_addr_ok;
  assign pop  = ~rst & ram_data_ok & ~empty;

  assign if_data_ok  = pop & ~head;
  assign mem_data_ok = pop & head;
  assign if_rdata    = ram_rdata;
  assign mem_rdata   = ram_rdata;
  assign err         = err_q;

  always_comb begin
    owner_d = owner_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    err_d   = err_q | (ram_data_ok & empty);
    if (push) begin
      owner_d[wptr_q] = grant_mem;
      wptr_d          = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed bench for ram_arbiter with a queue-based reference model
module tb_ram_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_write, mem_req, mem_write;
  logic [3:0]  if_wstrb, mem_wstrb;
  logic [31:0] if_addr, if_wdata, mem_addr, mem_wdata;
  logic if_addr_ok, if_data_ok, mem_addr_ok, mem_data_ok;
  logic [31:0] if_rdata, mem_rdata;
  logic ram_req, ram_write;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic ram_addr_ok, ram_data_ok, err;

  int checks = 0;
  int failures = 0;

  ram_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_write(if_write), .if_wstrb(if_wstrb), .if_addr(if_addr),
    .if_wdata(if_wdata), .if_addr_ok(if_addr_ok), .if_data_ok(if_data_ok), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .ram_req(ram_req), .ram_write(ram_write), .ram_wstrb(ram_wstrb), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok), .ram_rdata(ram_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding owners in acceptance order (1 = MEM), plus sticky error.
  bit owners[$];
  bit err_m = 1'b0;

  always @(negedge clk) begin
    bit full_m, empty_m, gm, gi, exp_ifd, exp_memd;
    if (rst) begin
      chk("m_rst_ram_req", {31'b0, ram_req}, 32'd0);
      chk("m_rst_addr_ok", {30'b0, if_addr_ok, mem_addr_ok}, 32'd0);
      chk("m_rst_data_ok", {30'b0, if_data_ok, mem_data_ok}, 32'd0);
      owners.delete();
      err_m = 1'b0;
    end else begin
      full_m  = (owners.size() == DEPTH);
      empty_m = (owners.size() == 0);
      gm = mem_req && !full_m;
      gi = if_req && !mem_req && !full_m;
      exp_ifd  = ram_data_ok && !empty_m && (owners[0] == 1'b0);
      exp_memd = ram_data_ok && !empty_m && (owners[0] == 1'b1);
      chk("m_ram_req", {31'b0, ram_req}, {31'b0, gm | gi});
      chk("m_ram_addr", ram_addr, gm ? mem_addr : if_addr);
      chk("m_ram_wdata", ram_wdata, gm ? mem_wdata : if_wdata);
      chk("m_ram_ctl", {27'b0, ram_write, ram_wstrb},
          gm ? {27'b0, mem_write, mem_wstrb} : {27'b0, if_write, if_wstrb});
      chk("m_mem_addr_ok", {31'b0, mem_addr_ok}, {31'b0, gm && ram_addr_ok});
      chk("m_if_addr_ok", {31'b0, if_addr_ok}, {31'b0, gi && ram_addr_ok});
      chk("m_if_data_ok", {31'b0, if_data_ok}, {31'b0, exp_ifd});
      chk("m_mem_data_ok", {31'b0, mem_data_ok}, {31'b0, exp_memd});
      chk("m_rdata", if_rdata ^ mem_rdata ^ ram_rdata, ram_rdata);
      chk("m_err", {31'b0, err}, {31'b0, err_m});
      if (ram_data_ok && empty_m) err_m = 1'b1;
      if (ram_data_ok && !empty_m) void'(owners.pop_front());
      if ((gm || gi) && ram_addr_ok) owners.push_back(gm);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 0; mem_req = 0; ram_addr_ok = 0; ram_data_ok = 0;
  endtask

  initial begin
    rst = 1; idle();
    if_write = 0; mem_write = 1; if_wstrb = 4'h0; mem_wstrb = 4'hF;
    if_addr = 0; if_wdata = 32'h1111_1111; mem_addr = 0; mem_wdata = 32'h2222_2222;
    ram_rdata = 0;
    step(); step();
    rst = 0;
    @(negedge clk);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_ram_req", {31'b0, ram_req}, 32'd0);
    step();

    // Single IF read returning two cycles later.
    if_req = 1; if_addr = 32'h100; ram_addr_ok = 1;
    @(negedge clk);
    chk("s1_if_addr_ok", {31'b0, if_addr_ok}, 32'd1);
    chk("s1_ram_addr", ram_addr, 32'h100);
    step(); idle();
    step();
    ram_data_ok = 1; ram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("s1_if_data_ok", {31'b0, if_data_ok}, 32'd1);
    chk("s1_mem_data_ok", {31'b0, mem_data_ok}, 32'd0);
    chk("s1_if_rdata", if_rdata, 32'hDEADBEEF);
    step(); idle();
    chk("s1_model_empty", owners.size(), 32'd0);

    // Simultaneous requests: MEM first, IF next; responses in order.
    if_req = 1; mem_req = 1; if_addr = 32'h200; mem_addr = 32'h300; ram_addr_ok = 1;
    @(negedge clk);
    chk("s2_mem_addr_ok", {31'b0, mem_addr_ok}, 32'd1);
    chk("s2_if_addr_ok0", {31'b0, if_addr_ok}, 32'd0);
    chk("s2_ram_addr", ram_addr, 32'h300);
    step(); mem_req = 0;
    @(negedge clk);
    chk("s2_if_addr_ok1", {31'b0, if_addr_ok}, 32'd1);
    step(); idle(); ram_data_ok = 1; ram_rdata = 32'hA;
    @(negedge clk);
    chk("s2_mem_data_ok", {31'b0, mem_data_ok}, 32'd1);
    chk("s2_if_data_ok0", {31'b0, if_data_ok}, 32'd0);
    step(); ram_rdata = 32'hB;
    @(negedge clk);
    chk("s2_if_data_ok", {31'b0, if_data_ok}, 32'd1);
    step(); idle();

    // Five back-to-back IF reads against a stalled slave.
    if_req = 1; ram_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      if_addr = 32'h400 + 4 * i;
      @(negedge clk);
      chk("s3_accept", {31'b0, if_addr_ok}, 32'd1);
      step();
    end
    if_addr = 32'h410;
    @(negedge clk);
    chk("s3_full_ram_req", {31'b0, ram_req}, 32'd0);
    chk("s3_full_addr_ok", {31'b0, if_addr_ok}, 32'd0);
    step(); ram_data_ok = 1; ram_rdata = 32'h55;
    @(negedge clk);
    chk("s3_pop_data_ok", {31'b0, if_data_ok}, 32'd1);
    chk("s3_pop_no_accept", {31'b0, if_addr_ok}, 32'd0);
    step(); ram_data_ok = 0;
    @(negedge clk);
    chk("s3_fifth_accept", {31'b0, if_addr_ok}, 32'd1);
    step(); idle(); ram_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s3_drain", {31'b0, if_data_ok}, 32'd1);
      step();
    end
    idle();

    // Interleaved IF/MEM with pointer wrap; one accept and one response per cycle.
    for (int i = 0; i <= 12; i++) begin
      if_req = (i < 12) && (i % 2 == 0);
      mem_req = (i < 12) && (i % 2 == 1);
      if_addr = 32'h1000 + 4 * i; mem_addr = 32'h2000 + 4 * i;
      ram_addr_ok = (i < 12);
      ram_data_ok = (i > 0); ram_rdata = 32'hA0 + i - 1;
      @(negedge clk);
      if (i < 12)
        chk("s4_addr_ok", {30'b0, mem_addr_ok, if_addr_ok}, (i % 2 == 1) ? 32'd2 : 32'd1);
      if (i > 0)
        chk("s4_data_ok", {30'b0, mem_data_ok, if_data_ok}, ((i - 1) % 2 == 1) ? 32'd2 : 32'd1);
      step();
    end
    idle();

    // Stray response with nothing outstanding.
    ram_data_ok = 1;
    @(negedge clk);
    chk("s5_no_data_ok", {30'b0, mem_data_ok, if_data_ok}, 32'd0);
    step(); ram_data_ok = 0;
    @(negedge clk);
    chk("s5_err_set", {31'b0, err}, 32'd1);
    step(); step();
    chk("s5_err_sticky", {31'b0, err}, 32'd1);
    rst = 1; #1;
    chk("s5_err_cleared", {31'b0, err}, 32'd0);
    step(); rst = 0; step();

    // Reset with three outstanding requests.
    if_req = 1; ram_addr_ok = 1;
    step(); step(); step();
    mem_req = 1; ram_data_ok = 1;
    #2; rst = 1; #1;
    chk("s6_async_ram_req", {31'b0, ram_req}, 32'd0);
    chk("s6_async_addr_ok", {30'b0, mem_addr_ok, if_addr_ok}, 32'd0);
    chk("s6_async_data_ok", {30'b0, mem_data_ok, if_data_ok}, 32'd0);
    step(); idle(); rst = 0; ram_data_ok = 1;
    @(negedge clk);
    chk("s6_empty_no_data_ok", {30'b0, mem_data_ok, if_data_ok}, 32'd0);
    step(); ram_data_ok = 0;
    chk("s6_count_zero_err", {31'b0, err}, 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
